// File: rtl/div_pkg.sv
// Shared encodings for the restoring divider sequencer: FSM states, shift-register
// select codes and remainder-source mux codes.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIN  = 3'd3,
        S_DZ   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_SHL  = 2'd2;
    localparam logic [1:0] SEL_SHR  = 2'd3;

    localparam logic MUX_ZERO = 1'b0;
    localparam logic MUX_DIFF = 1'b1;

endpackage

// File: rtl/div_iter_cnt.sv
// Iteration counter for the divider sequencer: synchronous clear-to-zero and
// increment, with terminal count flagged on the last of N iterations.
module div_iter_cnt #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic cnt_clr,
    input  logic cnt_inc,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (cnt_clr) begin
            count <= '0;
        end else if (cnt_inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(N - 1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencing FSM for the restoring shift-subtract divider datapath.
// Optional build macro DIV_ABORT_EN adds an abort input that cancels LOAD/ITER.
//
// state  | meaning
// IDLE   | waiting for start; selects hold
// LOAD   | load dividend, divisor, clear remainder, zero the counter
// ITER   | one shift/subtract step per cycle, N cycles
// FIN    | one-cycle done pulse
// DZ     | divide-by-zero: done pulse, dz_err set on exit
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       div_zero,
    input  logic       rem_ge,
    input  logic       q_msb,
`ifdef DIV_ABORT_EN
    input  logic       abort,
`endif
    output logic [1:0] r_sel,
    output logic       r_dbit,
    output logic [1:0] q_sel,
    output logic       q_dbit,
    output logic       mux_sel,
    output logic       d_ld,
    output logic       busy,
    output logic       done,
    output logic       dz_err
);

    state_t state, state_n;
    logic   cnt_clr, cnt_inc, tc;

    div_iter_cnt #(.N(N), .CW(CW)) u_iter_cnt (
        .clk     (clk),
        .clr     (clr),
        .cnt_clr (cnt_clr),
        .cnt_inc (cnt_inc),
        .tc      (tc)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Cleared by any accepted start; set as DZ hands back to IDLE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dz_err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            dz_err <= 1'b0;
        end else if (state == S_DZ) begin
            dz_err <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        r_sel   = SEL_HOLD;
        r_dbit  = 1'b0;
        q_sel   = SEL_HOLD;
        q_dbit  = 1'b0;
        mux_sel = MUX_ZERO;
        d_ld    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = div_zero ? S_DZ : S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_n = S_ITER;
                q_sel   = SEL_LOAD;
                r_sel   = SEL_LOAD;
                mux_sel = MUX_ZERO;
                d_ld    = 1'b1;
                cnt_clr = 1'b1;
`ifdef DIV_ABORT_EN
                if (abort) begin
                    state_n = S_IDLE;
                    q_sel   = SEL_HOLD;
                    r_sel   = SEL_HOLD;
                    d_ld    = 1'b0;
                    cnt_clr = 1'b0;
                end
`endif
            end
            S_ITER: begin
                busy    = 1'b1;
                cnt_inc = 1'b1;
                q_sel   = SEL_SHL;
                q_dbit  = rem_ge;
                if (rem_ge) begin
                    r_sel   = SEL_LOAD;
                    mux_sel = MUX_DIFF;
                end else begin
                    r_sel   = SEL_SHL;
                    r_dbit  = q_msb;
                end
                state_n = tc ? S_FIN : S_ITER;
`ifdef DIV_ABORT_EN
                // Abort outranks the terminal-count exit.
                if (abort) begin
                    state_n = S_IDLE;
                    cnt_inc = 1'b0;
                    q_sel   = SEL_HOLD;
                    q_dbit  = 1'b0;
                    r_sel   = SEL_HOLD;
                    r_dbit  = 1'b0;
                    mux_sel = MUX_ZERO;
                end
`endif
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            S_DZ: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: a behavioural datapath closes the loop,
// results are compared against plain integer division.
module tb_div_seq_ctrl;
    import div_pkg::*;

    localparam int N  = 8;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       div_zero, rem_ge, q_msb;
`ifdef DIV_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [1:0] r_sel, q_sel;
    logic       r_dbit, q_dbit, mux_sel, d_ld, busy, done, dz_err;

    logic [N-1:0] opa = '0, opb = '0;
    logic [N-1:0] qr, rr, dr;
    logic [N:0]   cand;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    div_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .div_zero (div_zero),
        .rem_ge   (rem_ge),
        .q_msb    (q_msb),
`ifdef DIV_ABORT_EN
        .abort    (abort),
`endif
        .r_sel    (r_sel),
        .r_dbit   (r_dbit),
        .q_sel    (q_sel),
        .q_dbit   (q_dbit),
        .mux_sel  (mux_sel),
        .d_ld     (d_ld),
        .busy     (busy),
        .done     (done),
        .dz_err   (dz_err)
    );

    // Behavioural datapath: remainder/quotient shift registers, divisor, comparator.
    always_comb begin
        cand     = {rr, qr[N-1]};
        rem_ge   = (cand >= {1'b0, dr});
        q_msb    = qr[N-1];
        div_zero = (opb == '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            qr <= '0;
            rr <= '0;
            dr <= '0;
        end else begin
            case (q_sel)
                SEL_LOAD: qr <= opa;
                SEL_SHL:  qr <= {qr[N-2:0], q_dbit};
                default:  qr <= qr;
            endcase
            case (r_sel)
                SEL_LOAD: rr <= (mux_sel == MUX_DIFF) ? N'(cand - {1'b0, dr}) : '0;
                SEL_SHL:  rr <= {rr[N-2:0], r_dbit};
                default:  rr <= rr;
            endcase
            if (d_ld) dr <= opb;
        end
    end

    function automatic int out_vec();
        return int'({r_sel, r_dbit, q_sel, q_dbit, mux_sel, d_ld, busy, done, dz_err});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input bit edz, input string tag);
        int done_cyc = -1, n_done = 0, n_act = 0, n_iter = 0, dz1 = 0;
        logic [N-1:0] q_at = '0, r_at = '0;
        logic [15:0] rs_obs = '0, rs_exp = '0;
        for (int i = 0; i < N; i++) rs_exp = {rs_exp[13:0], (eq[N-1-i] ? SEL_LOAD : SEL_SHL)};
        @(posedge clk); #1;
        opa = a; opb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (k == 1) dz1 = int'(dz_err);
            if (q_sel == SEL_SHL) begin
                n_iter++;
                rs_obs = {rs_obs[13:0], r_sel};
            end
            if (q_sel != SEL_HOLD || r_sel != SEL_HOLD || d_ld) n_act++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = k; q_at = qr; r_at = rr; end
            end
        end
        check({tag, " done_pulses"}, n_done, 1);
        check({tag, " busy_end"}, int'(busy), 0);
        if (edz) begin
            check({tag, " dz_done_cycle"}, done_cyc, 1);
            check({tag, " dz_no_activity"}, n_act, 0);
            check({tag, " dz_err_set"}, int'(dz_err), 1);
        end else begin
            check({tag, " done_cycle"}, done_cyc, N + 2);
            check({tag, " iterations"}, n_iter, N);
            check({tag, " quotient"}, int'(q_at), int'(eq));
            check({tag, " remainder"}, int'(r_at), int'(er));
            check({tag, " r_sel_seq"}, int'(rs_obs), int'(rs_exp));
            check({tag, " dz_err_cleared_at_accept"}, dz1, 0);
            check({tag, " dz_err_end"}, int'(dz_err), 0);
        end
    endtask

    typedef struct {
        logic [N-1:0] a, b, eq, er;
        bit           edz;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int load_cnt, done_cnt, bad_res;
        int load_cyc[3];
        int nd;
        logic [N-1:0] ra, rb;

        vecs[0] = '{a: 8'd100, b: 8'd7,   eq: 8'd14,  er: 8'd2, edz: 1'b0};
        vecs[1] = '{a: 8'd13,  b: 8'd0,   eq: 8'd0,   er: 8'd0, edz: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd5,   eq: 8'd0,   er: 8'd0, edz: 1'b0};
        vecs[3] = '{a: 8'd5,   b: 8'd200, eq: 8'd0,   er: 8'd5, edz: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd1,   eq: 8'd255, er: 8'd0, edz: 1'b0};
        vecs[5] = '{a: 8'd200, b: 8'd9,   eq: 8'd22,  er: 8'd2, edz: 1'b0};

        #2;
        check("reset_outputs", out_vec(), 0);
        @(posedge clk); @(posedge clk); #3;
        check("reset_outputs_held", out_vec(), 0);
        clr = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, $sformatf("vec%0d", i));

        // start held high: back-to-back operations, 255/1
        @(posedge clk); #1;
        opa = 8'd255; opb = 8'd1; start = 1'b1;
        load_cnt = 0; done_cnt = 0; bad_res = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (q_sel == SEL_LOAD) begin
                if (load_cnt < 3) load_cyc[load_cnt] = k;
                load_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (qr != 8'd255 || rr != 8'd0) bad_res++;
            end
            if (k == 30) start = 1'b0;
        end
        check("b2b_loads", load_cnt, 3);
        check("b2b_load0", load_cyc[0], 1);
        check("b2b_load_gap1", load_cyc[1] - load_cyc[0], 11);
        check("b2b_load_gap2", load_cyc[2] - load_cyc[1], 11);
        check("b2b_dones", done_cnt, 3);
        check("b2b_results_bad", bad_res, 0);

        // clr pulse in the fourth ITER cycle
        @(posedge clk); #1;
        opa = 8'd100; opb = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 2; k <= 5; k++) begin @(posedge clk); #1; end
        check("clr_busy_before", int'(busy), 1);
        clr = 1'b1;
        #1;
        check("clr_async_outputs", out_vec(), 0);
        #1;
        clr = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("clr_no_done_or_busy", nd, 0);
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "after_clr");

`ifdef DIV_ABORT_EN
        @(posedge clk); #1;
        opa = 8'd100; opb = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 2; k <= 4; k++) begin @(posedge clk); #1; end
        abort = 1'b1;
        #1;
        check("abort_sel_hold", int'({q_sel, r_sel}), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy_low", int'(busy), 0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        check("abort_no_done", nd, 0);
        run_op(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, "after_abort");
`endif

        for (int t = 0; t < 12; t++) begin
            ra = N'($urandom_range(0, 255));
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : N'($urandom_range(1, 255));
            if (rb == 0) run_op(ra, rb, 8'd0, 8'd0, 1'b1, $sformatf("rnd%0d", t));
            else         run_op(ra, rb, ra / rb, ra % rb, 1'b0, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing FSM for the restoring shift-subtract divider datapath: remainder and quotient universal shift registers, divisor register, two's-complement adder, remainder-source mux, and comparator.
- Accepts a start/done handshake, issues the one-cycle operand load, then runs N shift/subtract iterations with an internal iteration counter.
- Flags divide-by-zero.
- Sits between the top-level divider wrapper and the datapath submodules.

Parameters:
- N, 8: operand width; number of iterations.
- CW, 3: iteration counter width; must satisfy 2^CW >= N.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE.
- div_zero  in  1  divisor operand == 0, from the datapath comparator.
- rem_ge  in  1  shifted remainder candidate >= divisor, from the datapath comparator.
- q_msb  in  1  current quotient register MSB.
- r_sel  out  2  remainder register select: 0 hold, 1 load, 2 shift left.
- r_dbit  out  1  remainder shift-in bit.
- q_sel  out  2  quotient register select: 0 hold, 1 load, 2 shift left.
- q_dbit  out  1  quotient shift-in bit.
- mux_sel  out  1  remainder load source: 0 = zero, 1 = adder difference.
- d_ld  out  1  divisor register load.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- dz_err  out  1  sticky divide-by-zero flag.

Behaviour:
- Reset (clr=1, async):
  - state = IDLE, iteration counter = 0, dz_err = 0.
  - All outputs take IDLE values: r_sel = q_sel = 0, d_ld = 0, mux_sel = 0, r_dbit = q_dbit = 0, busy = 0, done = 0.
- States (state register 3 bits): IDLE, LOAD, ITER, FIN, DZ.
- IDLE:
  - All selects hold.
  - start=1 and div_zero=1 -> DZ.
  - start=1 and div_zero=0 -> LOAD.
  - Either accepted start clears dz_err at that edge; DZ then re-sets it.
- LOAD (1 cycle):
  - q_sel=1 (load dividend), d_ld=1, r_sel=1 with mux_sel=0 (clear remainder), counter <= 0, busy=1.
  - Next state ITER.
- ITER (exactly N cycles), busy=1; outputs are Mealy on rem_ge:
  - q_sel=2, q_dbit=rem_ge.
  - rem_ge=1: r_sel=1, mux_sel=1 (load difference).
  - rem_ge=0: r_sel=2, r_dbit=q_msb.
  - Counter increments each cycle; when counter == N-1 -> FIN, else stay in ITER.
- FIN (1 cycle): all selects hold, done=1, busy=0. Next state IDLE.
- DZ (1 cycle): no loads, done=1, dz_err set (registered, stays high until next accepted start). Next state IDLE.
- Latency: start sampled at edge 0 -> LOAD in cycle 1, ITER in cycles 2..N+1, done high in cycle N+2, IDLE in cycle N+3. A back-to-back start can be sampled in cycle N+3.
- start outside IDLE (LOAD, ITER, FIN, DZ) is ignored and not queued.
- rem_ge is don't-care outside ITER; div_zero is don't-care outside IDLE.
- clr mid-operation: immediate return to IDLE; datapath registers are reset by the same clr.
- Unused state encodings -> IDLE on next edge, all outputs at IDLE values.

Optional Feature:
- Macro DIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or ITER -> IDLE at next edge, no done pulse, selects hold during that cycle.
  - abort has priority over the counter terminal check.
  - abort is ignored in IDLE, FIN and DZ.
- Undefined: port absent; an operation always runs to FIN.

Decomposition:
- Shared package div_pkg:
  - State encoding localparams S_IDLE=0, S_LOAD=1, S_ITER=2, S_FIN=3, S_DZ=4.
  - Select-code localparams SEL_HOLD=0, SEL_LOAD=1, SEL_SHL=2, SEL_SHR=3.
  - MUX_ZERO=0, MUX_DIFF=1.
- Sub-module: iteration counter as div_iter_cnt (CW-bit, synchronous load-zero and increment, terminal-count output tc = (count == N-1)).
- Remainder of the block is one state register, next-state logic, and an output decode.

Test Plan:
- Basic divide, N=8, behavioural datapath model, dividend 100 / divisor 7 (rem_ge sequence 0,0,0,0,1,1,1,0):
  - done high exactly 10 cycles after the start edge.
  - Quotient 14, remainder 2.
  - Per-cycle r_sel sequence 2,2,2,2,1,1,1,2.
- Divide by zero, div_zero=1 with start:
  - DZ entered; done=1 for one cycle; dz_err=1; no q_sel/r_sel/d_ld activity.
  - Next start with div_zero=0 clears dz_err at the accept edge.
- start held high for 30 cycles, 255 / 1:
  - Operations back-to-back, new LOAD every 11 cycles.
  - Quotient 255, remainder 0; no start accepted while busy.
- clr pulsed at ITER cycle 4:
  - Outputs return to IDLE values asynchronously; no done pulse.
  - Next start runs a full 10-cycle operation.
- DIV_ABORT_EN defined, abort at ITER cycle 3:
  - IDLE next edge; done never asserts; busy low.
  - Subsequent 200 / 9 yields quotient 22, remainder 2.
- Edge operands 0 / 5 and 5 / 200:
  - Quotient 0, remainder 0 and quotient 0, remainder 5 respectively; rem_ge never asserted; done still at cycle 10.
